// File: rtl/fetch_unit_pkg.sv
// Shared CPU front-end definitions: instruction/PC widths, bubble encoding,
// fetch FSM states and the buffered fetch entry.
package fetch_unit_pkg;
  localparam int INSN_W = 16;
  localparam int PC_W   = 16;
  localparam logic [INSN_W-1:0] NOP_INSN = 16'h3000;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer; slot 0 is always the head.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   din_pc_i,
  input  logic [INSN_W-1:0] din_insn_i,
  output logic [PC_W-1:0]   head_pc_o,
  output logic [INSN_W-1:0] head_insn_o,
  output logic              empty_o,
  output logic              full_o
);
  fetch_entry_t slot_q [2];
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_after_pop;
  logic         do_pop, do_push;

  assign empty_o       = (cnt_q == 2'd0);
  assign full_o        = (cnt_q == 2'd2);
  assign do_pop        = pop_i && !empty_o;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push       = push_i && (!full_o || do_pop);
  assign cnt_after_pop = cnt_q - {1'b0, do_pop};
  assign head_pc_o     = slot_q[0].pc;
  assign head_insn_o   = slot_q[0].insn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 2'd0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else if (flush_i) begin
      cnt_q <= 2'd0;
    end else begin
      if (do_pop) slot_q[0] <= slot_q[1];
      if (do_push) begin
        if (cnt_after_pop == 2'd0) slot_q[0] <= '{pc: din_pc_i, insn: din_insn_i};
        else                       slot_q[1] <= '{pc: din_pc_i, insn: din_insn_i};
      end
      cnt_q <= cnt_after_pop + {1'b0, do_push};
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requests, 2-deep buffer to decode,
// redirect flush with discard of the in-flight response.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INSN = fetch_unit_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] w_insn,
  output logic        insn_valid,
  output logic [15:0] insn_pc
);
  import fetch_unit_pkg::*;

  fetch_state_e      state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   rsp_pc_q;
  logic              drop_q;
  logic              fifo_empty, fifo_full;
  logic              accept, push, pop;
  logic [PC_W-1:0]   head_pc;
  logic [INSN_W-1:0] head_insn;

  // Only request with a free slot, so every response has somewhere to land.
  assign imem_req  = rst_n && (state_q == IDLE) && !fifo_full && !redirect_valid;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;
  assign push      = (state_q == WAIT) && imem_rvalid && !drop_q && !redirect_valid;
  assign pop       = !fifo_empty && !stall;

  assign insn_valid = !fifo_empty;
  assign w_insn     = fifo_empty ? NOP_INSN : head_insn;
  assign insn_pc    = fifo_empty ? '0 : head_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      rsp_pc_q <= '0;
      drop_q   <= 1'b0;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
      // Response still in flight: stay in WAIT and swallow it when it lands.
      if (state_q == WAIT && !imem_rvalid) begin
        drop_q <= 1'b1;
      end else begin
        state_q <= IDLE;
        drop_q  <= 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          pc_q     <= pc_q + PC_W'(1);
          rsp_pc_q <= pc_q;
          state_q  <= WAIT;
        end
        WAIT: if (imem_rvalid) begin
          state_q <= IDLE;
          drop_q  <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .din_pc_i    (rsp_pc_q),
    .din_insn_i  (imem_rdata),
    .head_pc_o   (head_pc),
    .head_insn_o (head_insn),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a 1-cycle imem responder, an expected
// instruction queue and a request model, checked every cycle.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [15:0] imem_rdata = '0, redirect_pc = '0;
  logic        imem_req, insn_valid;
  logic [15:0] imem_addr, w_insn, insn_pc;

  typedef struct { logic [15:0] pc; logic [15:0] insn; } exp_t;
  exp_t sb[$];
  int   n_run = 0, n_fail = 0;
  logic pend = 1'b0, stale = 1'b0, hold_resp = 1'b0, force_en = 1'b0;
  logic [15:0] pend_addr = '0, exp_pc = 16'h0000, force_data = '0;

  fetch_unit #(.RESET_PC(16'h0000), .NOP_INSN(16'h3000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .w_insn(w_insn), .insn_valid(insn_valid), .insn_pc(insn_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_req", 16'(imem_req), 16'h0000);
    chk("rst_valid", 16'(insn_valid), 16'h0000);
    chk("rst_insn", w_insn, 16'h3000);
    chk("rst_pc", insn_pc, 16'h0000);
  endtask

  // Called at posedge+1 with stall/ready/redirect already set for this cycle.
  task automatic cyc();
    logic exp_req;
    exp_t e;
    imem_rvalid = pend && !hold_resp;
    imem_rdata  = force_en ? force_data : mem_data(pend_addr);
    #1;
    exp_req = !pend && (sb.size() < 2) && !redirect_valid;
    chk("req", 16'(imem_req), 16'(exp_req));
    chk("valid", 16'(insn_valid), 16'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("insn", w_insn, sb[0].insn);
      chk("insn_pc", insn_pc, sb[0].pc);
    end else begin
      chk("nop_insn", w_insn, 16'h3000);
      chk("nop_pc", insn_pc, 16'h0000);
    end
    if (redirect_valid) begin
      sb.delete();
      exp_pc = redirect_pc;
      if (pend && !imem_rvalid) stale = 1'b1;
      else if (pend) begin pend = 1'b0; stale = 1'b0; end
    end else begin
      if (sb.size() != 0 && !stall) void'(sb.pop_front());
      if (imem_rvalid) begin
        if (!stale) begin e.pc = pend_addr; e.insn = imem_rdata; sb.push_back(e); end
        pend = 1'b0;
        stale = 1'b0;
      end
      if (imem_req && imem_ready) begin
        chk("addr", imem_addr, exp_pc);
        pend_addr = exp_pc;
        exp_pc++;
        pend = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_pend();
    for (int i = 0; i < 10 && !pend; i++) cyc();
    chk("pend_timeout", 16'(pend), 16'h0001);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset();
    rst_n = 1'b1;
    imem_ready = 1'b1;

    // streaming fetch
    repeat (12) cyc();

    // back-pressure fills the buffer
    stall = 1'b1; repeat (6) cyc();
    stall = 1'b0; repeat (8) cyc();

    // redirect while waiting, stale response next cycle
    wait_pend();
    hold_resp = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040; cyc();
    hold_resp = 1'b0; redirect_valid = 1'b0; force_en = 1'b1; force_data = 16'hDEAD; cyc();
    force_en = 1'b0;
    repeat (6) cyc();

    // redirect coincident with response
    wait_pend();
    redirect_valid = 1'b1; redirect_pc = 16'h0040; cyc();
    redirect_valid = 1'b0; repeat (4) cyc();

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF; cyc();
    redirect_valid = 1'b0; repeat (8) cyc();

    // random mix
    for (int i = 0; i < 300; i++) begin
      stall          = ($urandom_range(3) == 0);
      imem_ready     = ($urandom_range(3) != 0);
      hold_resp      = ($urandom_range(4) == 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = 16'($urandom);
      cyc();
    end
    stall = 1'b0; imem_ready = 1'b1; hold_resp = 1'b0; redirect_valid = 1'b0;
    repeat (6) cyc();

    // reset mid-WAIT with a response arriving during reset
    wait_pend();
    rst_n = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'hBEEF;
    #1 chk_reset();
    @(posedge clk); #1 chk_reset();
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    pend = 1'b0; stale = 1'b0; sb.delete(); exp_pc = 16'h0000;
    rst_n = 1'b1;
    repeat (8) cyc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSN, default 16'h3000: bubble driven to decode when no instruction is valid.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  16  word address of the request.
REQ-007 SHALL have port imem_ready  input  1  memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid.
REQ-009 SHALL have port imem_rdata  input  16  returned instruction word.
REQ-010 SHALL have port stall  input  1  decode cannot consume this cycle.
REQ-011 SHALL have port redirect_valid  input  1  control-flow change request.
REQ-012 SHALL have port redirect_pc  input  16  new fetch address.
REQ-013 SHALL have port w_insn  output  16  instruction presented to decode.
REQ-014 SHALL have port insn_valid  output  1  w_insn holds a real instruction.
REQ-015 SHALL have port insn_pc  output  16  address of the instruction on w_insn.

Function
REQ-016 SHALL keep a fetch PC, word-addressed, incremented by 1 per accepted request, wrapping 16'hFFFF -> 16'h0000.
REQ-017 SHALL buffer returned words with their PC in a 2-entry FIFO (depth exactly 2).
REQ-018 SHALL have at most one outstanding request; FSM states IDLE (none outstanding) and WAIT (one outstanding).
REQ-019 SHALL assert imem_req in IDLE only when FIFO occupancy is 0 or 1 with no pop pending beyond capacity, i.e. free slots > 0, and redirect_valid is low; imem_addr = fetch PC.
REQ-020 SHALL treat a request as accepted when imem_req && imem_ready: IDLE->WAIT, PC+1.
REQ-021 SHALL, in WAIT on imem_rvalid, push {PC, imem_rdata} unless the response is marked drop, and go WAIT->IDLE.
REQ-022 SHALL ignore imem_rvalid while in IDLE.
REQ-023 SHALL drive w_insn/insn_pc from the FIFO head combinationally; insn_valid = FIFO non-empty.
REQ-024 SHALL drive w_insn = NOP_INSN and insn_pc = 16'h0000 when the FIFO is empty.
REQ-025 SHALL pop the head when insn_valid && !stall.
REQ-026 SHALL, on redirect_valid, flush the FIFO, load PC = redirect_pc, and suppress imem_req that cycle; redirect has priority over push, pop and accept.
REQ-027 SHALL, on redirect_valid in WAIT without imem_rvalid the same cycle, set a drop flag so the in-flight response is discarded; drop clears on that response.
REQ-028 SHALL, on redirect_valid with imem_rvalid the same cycle, discard that response and go to IDLE.
REQ-029 SHALL support simultaneous push and pop when full (occupancy remains 2, order preserved).
REQ-030 SHALL never push when full; REQ-019 guarantees a slot exists for every outstanding response.

Reset
REQ-031 SHALL, while rst_n is low: PC = RESET_PC, FIFO empty, state IDLE, drop = 0, imem_req = 0, insn_valid = 0, w_insn = NOP_INSN, insn_pc = 16'h0000.
REQ-032 SHALL discard any response arriving during reset or from a request issued before reset.
REQ-033 SHALL issue the first request (imem_addr = RESET_PC) in the first cycle after rst_n rises.

Structure
REQ-034 SHALL place NOP_INSN, instruction width (16), and PC width (16) in the shared CPU package used by decode.
REQ-035 SHALL implement the buffer as one sub-module fetch_fifo (2-entry, push/pop/flush, full/empty).

Verification
REQ-036 Reset release, imem_ready=1, 1-cycle latency, stall=0 -> addresses 0,1,2..., w_insn shows rdata in order, insn_pc 0,1,2.
REQ-037 stall=1 for 6 cycles -> FIFO fills to 2, imem_req drops, w_insn/insn_pc held; release -> order preserved, no loss.
REQ-038 Redirect to 16'h0040 while WAIT; stale rdata 16'hDEAD returns next cycle -> DEAD never valid; next imem_addr 16'h0040.
REQ-039 Redirect same cycle as imem_rvalid -> response dropped, FIFO empty, w_insn = 16'h3000, next request 16'h0040.
REQ-040 PC at 16'hFFFF -> next request 16'h0000, insn_pc sequence FFFF then 0000.
REQ-041 rst_n low mid-WAIT, response arrives during reset -> after release FIFO empty, first imem_addr = RESET_PC.
